// File: rtl/sram_seq_pkg.sv
// Shared types and constants for the SRAM request sequencer: FSM encoding,
// response-buffer depth and the read credit rule.
package sram_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } seq_state_e;

    localparam int RESP_DEPTH   = 2;
    localparam int CREDIT_LIMIT = RESP_DEPTH;

    // Buffered plus in-flight reads, less the one leaving this cycle, must stay under the limit.
    function automatic logic credit_ok(input logic [1:0] occ, input logic inflight, input logic pop);
        logic [2:0] used;
        used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return (used < 3'(CREDIT_LIMIT));
    endfunction

endpackage

// File: rtl/resp_fifo2.sv
// Two-entry response buffer; push and pop may coincide at any occupancy,
// including full, because the popped slot is the one being refilled.
module resp_fifo2 #(
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [1:0]        occupancy_o
);

    logic [DATA_W-1:0] mem_q [0:1];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic              do_push_s;
    logic              do_pop_s;

    assign full_o      = (occ_q == 2'd2);
    assign empty_o     = (occ_q == 2'd0);
    assign occupancy_o = occ_q;
    assign rdata_o     = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        do_pop_s  = pop_i && !empty_o;
        do_push_s = push_i && (!full_o || do_pop_s);
        wr_ptr_d  = wr_ptr_q ^ do_push_s;
        rd_ptr_d  = rd_ptr_q ^ do_pop_s;
        occ_d     = occ_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= {DATA_W{1'b0}};
            mem_q[1] <= {DATA_W{1'b0}};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/sram_req_sequencer.sv
// Front end for a single-port masked SRAM: zero-fills the array after reset,
// then maps a valid/ready request stream onto RW0 cycles with buffered read responses.
module sram_req_sequencer
    import sram_seq_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 256,
    parameter int MASK_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              inflight_q, inflight_d;
    logic              init_done_q, init_done_d;

    logic [1:0]        fifo_occ_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              pop_s;
    logic              credit_ok_s;
    logic              read_acc_s;

    assign resp_valid  = !fifo_empty_s;
    assign pop_s       = resp_valid && resp_ready;
    assign credit_ok_s = credit_ok(fifo_occ_s, inflight_q, pop_s) && (!fifo_full_s || pop_s);
    assign init_done   = init_done_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one idle cycle, a full clear pass, then run forever.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_CLEAR;
            ST_CLEAR: begin
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: clear writes from the counter, run passes the request straight through.
    always_comb begin
        req_ready  = 1'b0;
        read_acc_s = 1'b0;
        RW0_en     = 1'b0;
        RW0_wmode  = 1'b0;
        RW0_addr   = {ADDR_W{1'b0}};
        RW0_wmask  = {MASK_W{1'b0}};
        RW0_wdata  = {DATA_W{1'b0}};
        case (state_q)
            ST_CLEAR: begin
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_addr  = cnt_q;
                RW0_wmask = {MASK_W{1'b1}};
                RW0_wdata = {DATA_W{1'b0}};
            end
            ST_RUN: begin
                if (req_write) begin
                    req_ready = 1'b1;
                end else begin
                    req_ready = credit_ok_s;
                end
                read_acc_s = req_valid && !req_write && req_ready;
                RW0_en     = req_valid && req_ready;
                RW0_wmode  = req_write;
                RW0_addr   = req_addr;
                RW0_wmask  = req_wmask;
                RW0_wdata  = req_wdata;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Datapath next-state: clear counter wraps to 0 on its last step into run.
    always_comb begin
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
        inflight_d  = read_acc_s;
        init_done_d = (state_d == ST_RUN);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= {ADDR_W{1'b0}};
            inflight_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            inflight_q  <= inflight_d;
            init_done_q <= init_done_d;
        end
    end

    // Read data is only valid the cycle after the read, so it is captured unconditionally then.
    resp_fifo2 #(
        .DATA_W (DATA_W)
    ) u_resp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (RW0_rdata),
        .pop_i       (pop_s),
        .rdata_o     (resp_rdata),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .occupancy_o (fifo_occ_s)
    );

endmodule
